// File: rtl/small_osc_2nd.sv
// Burst sine source: multiplier-free 2^-K rotation oscillator behind a
// start/stop FSM with an optional sample-count limit.
module small_osc_2nd #(
    parameter int K_SHIFT   = 6,
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    input  logic                    stop,
    input  logic signed [WIDTH-1:0] amp,
    input  logic [CNT_WIDTH-1:0]    len,
    output logic signed [WIDTH-1:0] dataOut,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);

    localparam int SW = WIDTH + K_SHIFT + 2;
    localparam logic signed [WIDTH+1:0] SAT_HI = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] SAT_LO = {3'b111, {(WIDTH-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic signed [SW-1:0]    s_q, c_q;
    logic signed [SW-1:0]    s_d, c_d;
    logic signed [SW-1:0]    s_shift;
    logic signed [SW-1:0]    c_start;
    logic signed [WIDTH+1:0] s_int;
    logic signed [WIDTH-1:0] sample;
    logic signed [WIDTH-1:0] amp_clamp;
    logic [CNT_WIDTH-1:0]    cnt_q, len_q;
    logic signed [WIDTH-1:0] data_q;
    logic                    valid_q, busy_q, done_q;
    logic                    last_sample;

    always_comb begin
        s_shift   = s_q >>> K_SHIFT;
        // c is updated first and the new c drives s, which keeps the orbit closed
        c_d       = c_q - s_shift;
        s_d       = s_q + (c_d >>> K_SHIFT);
        s_int     = s_shift[WIDTH+1:0];
        sample    = s_int[WIDTH-1:0];
        if (s_int > SAT_HI) begin
            sample = SAT_HI[WIDTH-1:0];
        end else if (s_int < SAT_LO) begin
            sample = SAT_LO[WIDTH-1:0];
        end
        amp_clamp = amp[WIDTH-1] ? '0 : amp;
        c_start   = {{(K_SHIFT+2){1'b0}}, amp_clamp} << K_SHIFT;
    end

    assign last_sample = (len_q != '0) && (cnt_q == len_q - CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    if (en && start) begin
                        s_q     <= '0;
                        c_q     <= c_start;
                        cnt_q   <= '0;
                        len_q   <= len;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    if (en) begin
                        if (stop) begin
                            // abort: flag done right away, DONE then just closes out
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            data_q  <= sample;
                            valid_q <= 1'b1;
                            c_q     <= c_d;
                            s_q     <= s_d;
                            cnt_q   <= cnt_q + CNT_WIDTH'(1);
                            if (last_sample) begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    done_q  <= !done_q;
                    busy_q  <= !done_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dataOut = data_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_small_osc_2nd.sv
// Self-checking bench for small_osc_2nd: vector table, hand sequences and
// random bursts compared against an arithmetic model of the tone.
module tb_small_osc_2nd;

    localparam int K    = 6;
    localparam int W    = 16;
    localparam int CW   = 16;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam longint D = longint'(1) << K;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                en = 1'b0;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic signed [W-1:0] amp = '0;
    logic [CW-1:0]       len = '0;
    logic signed [W-1:0] dataOut;
    logic                valid, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    small_osc_2nd #(.K_SHIFT(K), .WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .amp(amp), .len(len), .dataOut(dataOut), .valid(valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        int amp;
        int len;
        int en_mode;
        int stop_at;
        bit start_mid;
        bit with_stop;
        int exp_cnt;
        int exp_s1;
        int exp_s2;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic longint floordiv(input longint x);
        return (x >= 0) ? x / D : -((-x + D - 1) / D);
    endfunction

    // Ideal burst: the rotation recurrence in plain integers, floor scaling, clipping
    function automatic void model(input int a, input int n, output int q[$]);
        longint s, c, v;
        q = {};
        if (a < 0) a = 0;
        c = longint'(a) * D;
        s = 0;
        for (int i = 0; i < n; i++) begin
            v = floordiv(s);
            if (v > MAXV) v = MAXV;
            if (v < -MAXV) v = -MAXV;
            q.push_back(int'(v));
            c = c - floordiv(s);
            s = s + floordiv(c);
        end
    endfunction

    task automatic run_burst(input string tag, input int a, input int n, input int en_mode,
                             input int stop_at, input bit start_mid, input bit with_stop,
                             output int got[$]);
        int  exp[$];
        int  cyc, gap, en_bad, last_v, done_cyc, bad, n_exp;
        bit  en_prev, seen_done, busy_at_done;
        got = {};
        amp = W'(a); len = CW'(n); start = 1'b1; stop = with_stop; en = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk({tag, " busy after start"}, busy, 1);
        cyc = 0; gap = 0; en_bad = 0; last_v = -1; done_cyc = -1;
        seen_done = 1'b0; busy_at_done = 1'b0;
        while (!seen_done && cyc < 20000) begin
            case (en_mode)
                0:       en = 1'b1;
                1:       en = cyc[0];
                default: en = 1'($urandom_range(0, 1));
            endcase
            if (stop_at >= 0 && got.size() == stop_at) begin
                stop = 1'b1;
                en   = 1'b1;
            end
            if (start_mid && cyc == 5) begin
                start = 1'b1; amp = 16'sd1000; len = CW'(7);
            end
            en_prev = en;
            step();
            cyc++;
            start = 1'b0; stop = 1'b0;
            if (valid) begin
                got.push_back(int'(dataOut));
                if (!en_prev) en_bad++;
                if (en_mode == 0 && last_v >= 0 && cyc - last_v > 1) gap++;
                last_v = cyc;
            end
            if (done) begin
                seen_done    = 1'b1;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
        end
        chk({tag, " done seen"}, seen_done, 1);
        chk({tag, " valid while en low"}, en_bad, 0);
        chk({tag, " valid gaps"}, gap, 0);
        if (stop_at < 0 || en_mode == 0)
            chk({tag, " done after last valid"}, done_cyc - last_v, 1);
        chk({tag, " busy during done"}, busy_at_done, 1);
        en = 1'($urandom_range(0, 1));
        step();
        chk({tag, " done one cycle"}, done, 0);
        chk({tag, " busy drops"}, busy, 0);
        n_exp = (stop_at >= 0 && (n == 0 || stop_at < n)) ? stop_at : n;
        model(a, n_exp, exp);
        chk({tag, " sample count"}, got.size(), exp.size());
        bad = -1;
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            if (bad < 0 && got[i] != exp[i]) bad = i;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s seq[%0d]: got %0d required %0d", tag, bad, got[bad], exp[bad]);
        end
        $display("[TB] burst %s amp=%0d len=%0d en_mode=%0d samples=%0d", tag, a, n, en_mode, got.size());
    endtask

    initial begin
        vec_t vecs[8];
        int   got[$];
        int   cyc, zc_prev, zc_bad, zc_n, pk_max, pk_min, a, n, mode, sa;
        logic signed [15:0] ra;

        vecs[0] = '{8191,   3, 0, -1, 1'b0, 1'b0,  3, 127, 255};
        vecs[1] = '{-5,     5, 0, -1, 1'b0, 1'b0,  5,   0,   0};
        vecs[2] = '{100,    4, 0, -1, 1'b0, 1'b0,  4,   1,   3};
        vecs[3] = '{32767,  2, 0, -1, 1'b0, 1'b0,  2, 511,   0};
        vecs[4] = '{8191,   0, 0, 10, 1'b0, 1'b0, 10, 127, 255};
        vecs[5] = '{8191,  40, 1, -1, 1'b0, 1'b0, 40, 127, 255};
        vecs[6] = '{8191,  30, 0, -1, 1'b1, 1'b0, 30, 127, 255};
        vecs[7] = '{8191,   1, 0, -1, 1'b0, 1'b1,  1,   0,   0};

        rst = 1'b0; en = 1'b1; start = 1'b1; amp = 16'sd8191; len = CW'(5);
        repeat (3) step();
        chk("reset dataOut", dataOut, 0);
        chk("reset valid", valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        start = 1'b0; rst = 1'b1;
        step();

        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("idle stop busy", busy, 0);
        chk("idle stop done", done, 0);
        $display("[TB] idle stop ignored");

        for (int v = 0; v < 8; v++) begin
            run_burst($sformatf("vec%0d", v), vecs[v].amp, vecs[v].len, vecs[v].en_mode,
                      vecs[v].stop_at, vecs[v].start_mid, vecs[v].with_stop, got);
            chk($sformatf("vec%0d count", v), got.size(), vecs[v].exp_cnt);
            if (got.size() > 0) chk($sformatf("vec%0d s0", v), got[0], 0);
            if (got.size() > 1) chk($sformatf("vec%0d s1", v), got[1], vecs[v].exp_s1);
            if (got.size() > 2) chk($sformatf("vec%0d s2", v), got[2], vecs[v].exp_s2);
        end

        run_burst("tone", 8191, 0, 0, 4096, 1'b0, 1'b0, got);
        zc_prev = -1; zc_bad = 0; zc_n = 0; pk_max = -100000; pk_min = 100000;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] > pk_max) pk_max = got[i];
            if (got[i] < pk_min) pk_min = got[i];
            if (i > 0 && ((got[i-1] >= 0) != (got[i] >= 0))) begin
                if (zc_prev >= 0 && (i - zc_prev < 200 || i - zc_prev > 202)) zc_bad++;
                zc_prev = i;
                zc_n++;
            end
        end
        chk("tone crossing spacing", zc_bad, 0);
        chk("tone crossings found", zc_n >= 19, 1);
        chk("tone peak max", pk_max >= 8051 && pk_max <= 8331, 1);
        chk("tone peak min", pk_min >= -8331 && pk_min <= -8051, 1);

        run_burst("sat", 32767, 0, 0, 450, 1'b0, 1'b0, got);
        pk_max = -100000; pk_min = 100000;
        foreach (got[i]) begin
            if (got[i] > pk_max) pk_max = got[i];
            if (got[i] < pk_min) pk_min = got[i];
        end
        chk("sat min above -32768", pk_min >= -32767, 1);
        chk("sat reaches peak", pk_max >= 32700, 1);

        amp = 16'sd8191; len = '0; start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midreset dataOut", dataOut, 0);
        chk("midreset valid", valid, 0);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        $display("[TB] reset mid-burst");
        step();
        run_burst("post_reset", 8191, 2, 0, -1, 1'b0, 1'b0, got);
        if (got.size() > 1) chk("post_reset s1", got[1], 127);

        amp = 16'sd8191; len = CW'(2); start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin step(); cyc++; end
        chk("restart first done", done, 1);
        start = 1'b1; len = CW'(3);
        step();
        start = 1'b0;
        chk("restart busy", busy, 1);
        got = {}; cyc = 0;
        while (got.size() < 3 && cyc < 100) begin
            step(); cyc++;
            if (valid) got.push_back(int'(dataOut));
        end
        chk("restart count", got.size(), 3);
        if (got.size() > 2) chk("restart s2", got[2], 255);
        repeat (3) step();
        $display("[TB] earliest restart samples=%0d", got.size());

        for (int r = 0; r < 6; r++) begin
            ra   = 16'($urandom_range(0, 65535));
            a    = int'(ra);
            n    = int'($urandom_range(1, 300));
            mode = int'($urandom_range(0, 2));
            sa   = -1;
            if ($urandom_range(0, 2) == 0 && n > 2) sa = int'($urandom_range(1, n - 1));
            run_burst($sformatf("rand%0d", r), a, n, mode, sa, 1'b0, 1'b0, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/small_osc_2nd.md
# small_osc_2nd

Second-order shift-coefficient oscillator that synthesises a sine burst for the small-filter family. It is the source end of the filter data path: its `dataOut` drives `dataIn` of a small filter block for in-system self-test and tone injection. It uses the same multiplier-free, 2^-K coefficient style as the filters. A start/stop FSM with a sample-count limit sets the burst length.

## Interface

**Parameters**
- `K_SHIFT`, 6 — rotation coefficient 2^-K_SHIFT. Tone frequency ≈ 2^-K_SHIFT/(2π) cycles/sample, about 402 samples/period at 6.
- `WIDTH`, 16 — output data width, signed.
- `CNT_WIDTH`, 16 — width of the burst-length counter.

**Ports**
- `clk`  input  1  system clock.
- `rst`  input  1  reset, synchronous, active-low.
- `en`  input  1  clock enable. When low, all state, the counter and `dataOut` hold, and `valid` is 0.
- `start`  input  1  begin a burst. Sampled only in IDLE with `en`=1.
- `stop`  input  1  abort a burst. Sampled only in RUN with `en`=1.
- `amp`  input  WIDTH  signed peak amplitude, latched on start.
- `len`  input  CNT_WIDTH  samples per burst, latched on start. 0 means continuous until `stop`.
- `dataOut`  output  WIDTH  signed sine sample.
- `valid`  output  1  `dataOut` holds a new sample this cycle.
- `busy`  output  1  high in RUN and DONE.
- `done`  output  1  one-cycle pulse at burst end.

## Operation

**Reset.** `rst`=0 at any clock edge, in any state, forces:
- state IDLE;
- internal `s`, `c`, count = 0;
- `dataOut`=0, `valid`=0, `busy`=0, `done`=0.

**State `s`, `c`.** Both are signed, WIDTH+K_SHIFT+2 bits, scaled by 2^K_SHIFT (K_SHIFT fractional bits plus 2 guard bits).

**Start.** A `start` accepted in IDLE does the following:
- `amp` is clamped to [0, 2^(WIDTH-1)-1]; negative values become 0.
- `s` = 0 and `c` = amp<<K_SHIFT.
- The count is cleared and `len` is latched.
- The state moves to RUN.

**RUN, per cycle with `en`=1:**
- Register the output: `dataOut` = sat(s>>>K_SHIFT) and `valid`=1. Saturation is to ±(2^(WIDTH-1)-1); the most negative code is never produced.
- Update the oscillator using the old `s`: c' = c − (s>>>K_SHIFT). Then s' = s + (c'>>>K_SHIFT), which uses the new c'. This ordering keeps the oscillator amplitude-stable; `>>>` is arithmetic and truncates toward −∞.
- Increment the count.
- If `len`≠0 and this sample is number `len`−1, the next state is DONE.
- If `stop`=1, the next state is DONE and no sample is emitted that cycle: `valid`=0 and the output is not updated.

**DONE.** `done`=1 and `valid`=0 for one cycle; the next state is IDLE. DONE does not depend on `en`.

**IDLE.** `valid`=0, and `dataOut` holds its last value.

**Ignored inputs:**
- `start` is ignored in RUN and DONE.
- `stop` is ignored in IDLE and DONE.
- If `start` and `stop` are both high in IDLE, `start` wins.

**Counter.** The count wraps modulo 2^CNT_WIDTH in continuous mode (`len`=0) and has no effect there.

## Timing

- `start` accepted at edge t → RUN from t. The first sample (value 0) is registered at edge t+1, with `valid` high in the following cycle. After that, one sample per enabled cycle.
- A burst of `len`=N gives exactly N `valid` cycles. `done` is asserted the cycle after the last `valid`, and `busy` drops the cycle after `done`.
- `stop` at edge t in RUN → `done` high in the cycle after edge t, and no further `valid`.
- When `en`=0 in RUN, the sample sequence pauses without loss. The sample emitted after `en` returns is the next one in the sequence.
- Earliest restart: a `start` asserted in the IDLE cycle after DONE.

## Test plan

- **Ramp-up values.** Reset, then `start` with K_SHIFT=6, WIDTH=16, `amp`=8191, `len`=3 → `valid` samples 0, 127, 255, then `done` for one cycle, then `busy`=0.
- **Continuous tone.** `len`=0, `amp`=8191, run 4096 samples:
  - zero-crossing spacing is 201±1 samples;
  - peaks stay within 8191±140;
  - `valid` is continuous.
- **Saturation and clamp.** `amp`=32767 → no sample exceeds 32767, and no sample equals −32768. `amp`=−5 → all samples are 0.
- **Stall and abort.** Toggle `en` every other cycle in RUN → the valid sample sequence matches the `en`=1 run exactly. Assert `stop` at sample 10 → 10 valid samples, then `done`.
- **Reset mid-burst and ignored start.** Pull `rst`=0 mid-burst → next cycle all outputs are 0, state IDLE, and a new `start` reproduces sample 0, 127. A `start` issued during RUN has no effect on the burst or its count.
